// File: rtl/rtc_bus_sequencer.sv
// Sequences one multiplexed address/data RTC bus transaction for a write or a read requester.
// Latency: grant edge + 10*STEP_CYCLES clocks of bus phases, then a one-cycle ack; strobes are registered.
// Backpressure: requests are level-held until ack; a request is sampled only at grant, nothing is queued.
module rtc_bus_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam int               PRE_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [3:0]       STEP_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  state_t            state, state_nx;
  logic [3:0]        step, step_nx;
  logic [PRE_W-1:0]  pre, pre_nx;
  op_t               op, op_nx;
  op_t               last_grant, last_grant_nx;
  logic [DATA_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              grant_wr;
  logic              capture;

  logic              cs_n_nx, rd_n_nx, wr_n_nx, a_d_nx, ad_oe_nx;
  logic [DATA_W-1:0] ad_out_nx;
  logic              busy_nx, wr_ack_nx, rd_ack_nx;

  // Sequencing: arbitration in IDLE, prescaled step counter in RUN.
  always_comb begin
    state_nx      = state;
    step_nx       = step;
    pre_nx        = pre;
    op_nx         = op;
    last_grant_nx = last_grant;
    addr_nx       = addr_q;
    data_nx       = data_q;
    grant_wr      = 1'b0;
    capture       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          grant_wr      = wr_req && (!rd_req || (last_grant == OP_RD));
          op_nx         = grant_wr ? OP_WR : OP_RD;
          last_grant_nx = grant_wr ? OP_WR : OP_RD;
          addr_nx       = grant_wr ? wr_addr : rd_addr;
          data_nx       = wr_data;
          state_nx      = ST_RUN;
          step_nx       = 4'd0;
          pre_nx        = '0;
        end
      end
      ST_RUN: begin
        if (pre == PRE_LAST) begin
          pre_nx  = '0;
          capture = (op == OP_RD) && (step == 4'd6);
          if (step == STEP_LAST) begin
            state_nx = ST_DONE;
            step_nx  = 4'd0;
          end else begin
            step_nx = step + 4'd1;
          end
        end else begin
          pre_nx = pre + 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so each strobe lines up with its step.
  always_comb begin
    cs_n_nx   = 1'b1;
    rd_n_nx   = 1'b1;
    wr_n_nx   = 1'b1;
    a_d_nx    = 1'b1;
    ad_oe_nx  = 1'b0;
    ad_out_nx = '0;
    busy_nx   = (state_nx != ST_IDLE);
    wr_ack_nx = (state_nx == ST_DONE) && (op_nx == OP_WR);
    rd_ack_nx = (state_nx == ST_DONE) && (op_nx == OP_RD);

    if (state_nx == ST_RUN) begin
      if ((step_nx >= 4'd1) && (step_nx <= 4'd3)) begin
        a_d_nx    = 1'b0;
        ad_oe_nx  = 1'b1;
        ad_out_nx = addr_nx;
      end
      if ((step_nx >= 4'd1) && (step_nx <= 4'd2)) begin
        cs_n_nx = 1'b0;
        wr_n_nx = 1'b0;
      end
      if (op_nx == OP_WR) begin
        if ((step_nx >= 4'd5) && (step_nx <= 4'd7)) begin
          ad_oe_nx  = 1'b1;
          ad_out_nx = data_nx;
        end
        if ((step_nx >= 4'd5) && (step_nx <= 4'd6)) begin
          cs_n_nx = 1'b0;
          wr_n_nx = 1'b0;
        end
      end else begin
        if ((step_nx >= 4'd5) && (step_nx <= 4'd6)) begin
          cs_n_nx = 1'b0;
          rd_n_nx = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      step       <= 4'd0;
      pre        <= '0;
      op         <= OP_RD;
      last_grant <= OP_RD;
      addr_q     <= '0;
      data_q     <= '0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= '0;
      busy       <= 1'b0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      pre        <= pre_nx;
      op         <= op_nx;
      last_grant <= last_grant_nx;
      addr_q     <= addr_nx;
      data_q     <= data_nx;
      cs_n       <= cs_n_nx;
      rd_n       <= rd_n_nx;
      wr_n       <= wr_n_nx;
      a_d        <= a_d_nx;
      ad_oe      <= ad_oe_nx;
      ad_out     <= ad_out_nx;
      busy       <= busy_nx;
      wr_ack     <= wr_ack_nx;
      rd_ack     <= rd_ack_nx;
    end
  end

  // Read byte is taken on the final clock of the strobed data step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (capture) begin
      rd_data <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: table of transactions on a STEP_CYCLES=2 instance,
// plus hand-written tie, reset, dropped-request and STEP_CYCLES=1 sequences.
module tb_rtc_bus_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  always #5 clk = ~clk;

  logic       wr_req, rd_req, wr_ack, rd_ack, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data, ad_out, ad_in;
  logic       cs_n, rd_n, wr_n, a_d, ad_oe;

  logic       s1_wr_req, s1_rd_req, s1_wr_ack, s1_rd_ack, s1_busy;
  logic [7:0] s1_wr_addr, s1_wr_data, s1_rd_addr, s1_rd_data, s1_ad_out, s1_ad_in;
  logic       s1_cs_n, s1_rd_n, s1_wr_n, s1_a_d, s1_ad_oe;

  rtc_bus_sequencer #(.STEP_CYCLES(S), .DATA_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_sequencer #(.STEP_CYCLES(1), .DATA_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_req(s1_wr_req), .wr_addr(s1_wr_addr), .wr_data(s1_wr_data), .wr_ack(s1_wr_ack),
    .rd_req(s1_rd_req), .rd_addr(s1_rd_addr), .rd_ack(s1_rd_ack), .rd_data(s1_rd_data),
    .busy(s1_busy), .cs_n(s1_cs_n), .rd_n(s1_rd_n), .wr_n(s1_wr_n), .a_d(s1_a_d),
    .ad_out(s1_ad_out), .ad_oe(s1_ad_oe), .ad_in(s1_ad_in)
  );

  logic [12:0] bus2, bus1;
  logic [2:0]  hs2, hs1;
  assign bus2 = {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out};
  assign bus1 = {s1_cs_n, s1_rd_n, s1_wr_n, s1_a_d, s1_ad_oe, s1_ad_out};
  assign hs2  = {busy, wr_ack, rd_ack};
  assign hs1  = {s1_busy, s1_wr_ack, s1_rd_ack};

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] din;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pin pattern {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out} for a given step.
  function automatic logic [12:0] exp_bus(input bit is_wr, input int st,
                                          input logic [7:0] addr, input logic [7:0] data);
    logic cs, rd, wr, ad, oe;
    logic [7:0] dout;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b1; oe = 1'b0; dout = 8'h00;
    if (st >= 1 && st <= 3) begin ad = 1'b0; oe = 1'b1; dout = addr; end
    if (st >= 1 && st <= 2) begin cs = 1'b0; wr = 1'b0; end
    if (is_wr && st >= 5 && st <= 7) begin oe = 1'b1; dout = data; end
    if (is_wr && st >= 5 && st <= 6) begin cs = 1'b0; wr = 1'b0; end
    if (!is_wr && st >= 5 && st <= 6) begin cs = 1'b0; rd = 1'b0; end
    return {cs, rd, wr, ad, oe, dout};
  endfunction

  // Called at the negedge just before the grant edge; returns at the idle negedge after DONE.
  task automatic txn_body(input bit is_wr, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] din, input logic [7:0] exp_rd, input int drop_step);
    int st;
    int n_ad;
    int n_cs;
    n_ad = 0;
    n_cs = 0;
    for (int c = 0; c < 10 * S; c++) begin
      @(negedge clk);
      st = c / S;
      chk($sformatf("bus c%0d", c), 32'(bus2), 32'(exp_bus(is_wr, st, addr, data)));
      chk($sformatf("hs run c%0d", c), 32'(hs2), 32'(3'b100));
      if (!a_d) n_ad++;
      if (!cs_n) n_cs++;
      if (!is_wr) ad_in = (st == 6) ? din : ~din;
      if (st == drop_step) begin
        if (is_wr) wr_req = 1'b0;
        else rd_req = 1'b0;
      end
    end
    chk("a_d low clocks", 32'(n_ad), 32'(3 * S));
    chk("cs_n low clocks", 32'(n_cs), 32'(4 * S));
    @(negedge clk);
    chk("hs done", 32'(hs2), 32'({1'b1, is_wr, !is_wr}));
    chk("bus done", 32'(bus2), 32'(exp_bus(is_wr, 0, addr, data)));
    chk("rd_data done", 32'(rd_data), 32'(exp_rd));
    if (is_wr) wr_req = 1'b0;
    else rd_req = 1'b0;
    ad_in = 8'h00;
    @(negedge clk);
    chk("hs idle", 32'(hs2), 32'(3'b000));
    chk("rd_data hold", 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_wr;

    vecs[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h02, 8'h00, 8'h59, 8'h59};
    vecs[2] = '{1'b1, 8'h10, 8'h3C, 8'h00, 8'h59};
    vecs[3] = '{1'b0, 8'h0F, 8'h00, 8'hA6, 8'hA6};
    vecs[4] = '{1'b0, 8'h7F, 8'h00, 8'hC3, 8'hC3};
    vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hC3};

    reset_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00; ad_in = 8'h00;
    s1_wr_req = 1'b0; s1_rd_req = 1'b0; s1_wr_addr = 8'h00; s1_wr_data = 8'h00;
    s1_rd_addr = 8'h00; s1_ad_in = 8'h00;

    repeat (2) @(negedge clk);
    chk("reset bus", 32'(bus2), 32'(exp_bus(1'b1, 0, 8'h00, 8'h00)));
    chk("reset hs", 32'(hs2), 32'(3'b000));
    chk("reset rd_data", 32'(rd_data), 32'(8'h00));
    chk("reset bus s1", 32'(bus1), 32'(exp_bus(1'b1, 0, 8'h00, 8'h00)));
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) begin
        wr_req = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      end else begin
        rd_req = 1'b1; rd_addr = vecs[i].addr;
      end
      txn_body(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].din, vecs[i].exp_rd, -1);
    end

    // Reset during step 5 of a write: strobes release at once, no ack, read byte cleared.
    wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
    for (int c = 0; c <= 10; c++) @(negedge clk);
    chk("pre-reset bus step5", 32'(bus2), 32'(exp_bus(1'b1, 5, 8'h33, 8'h77)));
    chk("pre-reset rd_data", 32'(rd_data), 32'(8'hC3));
    reset_n = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("mid-reset bus", 32'(bus2), 32'(exp_bus(1'b1, 0, 8'h00, 8'h00)));
    chk("mid-reset hs", 32'(hs2), 32'(3'b000));
    chk("mid-reset rd_data", 32'(rd_data), 32'(8'h00));
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("no ack after reset c%0d", c), 32'(hs2), 32'(3'b000));
    end

    // Simultaneous requests after reset: write first, read right after, then round-robin.
    wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
    rd_req = 1'b1; rd_addr = 8'h02;
    txn_body(1'b1, 8'h21, 8'h45, 8'h00, 8'h00, -1);
    txn_body(1'b0, 8'h02, 8'h00, 8'h59, 8'h59, -1);
    wr_req = 1'b1; wr_addr = 8'h0A; wr_data = 8'h0B;
    rd_req = 1'b1; rd_addr = 8'h0C;
    txn_body(1'b1, 8'h0A, 8'h0B, 8'h00, 8'h59, -1);
    txn_body(1'b0, 8'h0C, 8'h00, 8'h66, 8'h66, -1);

    // Read request withdrawn during step 3 still completes exactly once.
    rd_req = 1'b1; rd_addr = 8'h05;
    txn_body(1'b0, 8'h05, 8'h00, 8'h9A, 8'h9A, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("no second read c%0d", c), 32'(hs2), 32'(3'b000));
    end

    // Single-clock steps: whole transaction in 10 clocks, ack on the 11th.
    s1_wr_req = 1'b1; s1_wr_addr = 8'h21; s1_wr_data = 8'h45;
    n_wr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("s1 bus c%0d", c), 32'(bus1), 32'(exp_bus(1'b1, c, 8'h21, 8'h45)));
      chk($sformatf("s1 hs c%0d", c), 32'(hs1), 32'(3'b100));
      if (!s1_wr_n) n_wr++;
    end
    @(negedge clk);
    chk("s1 hs done", 32'(hs1), 32'(3'b110));
    chk("s1 wr_n low clocks", 32'(n_wr), 32'(4));
    s1_wr_req = 1'b0;
    @(negedge clk);
    chk("s1 hs idle", 32'(hs1), 32'(3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
